// File: rtl/rgb_cmp_arbiter.sv
// Two-requester round-robin arbiter that captures the winner's operands and
// shows their unsigned comparison on red/green/blue for HOLD_CYCLES cycles.
module rgb_cmp_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [1:0] a0,
  input  logic [1:0] b0,
  output logic       ack0,
  input  logic       req1,
  input  logic [1:0] a1,
  input  logic [1:0] b1,
  output logic       ack1,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] a_q, a_d, b_q, b_d;
  logic       gid_q, gid_d;
  logic       last_q, last_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d;
  logic       win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // On a tie the port not granted last wins; otherwise the lone requester.
  assign win = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    gid_d   = gid_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = SHOW;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          gid_d   = win;
          last_d  = win;
          cnt_d   = 8'(HOLD_CYCLES - 1);
          ack0_d  = ~win;
          ack1_d  = win;
        end
      end
      SHOW: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on state and captured registers, never on inputs.
  assign busy     = (state_q == SHOW);
  assign red      = busy && (a_q >  b_q);
  assign green    = busy && (a_q == b_q);
  assign blue     = busy && (a_q <  b_q);
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign grant_id = gid_q;

endmodule
